// File: rtl/neoprof_pkg.sv
// Shared NeoProf definitions: profiler register offsets and the drain master state encoding.
package neoprof_pkg;

  // Register offsets inside the profiler AVMM window (read and write decode separately).
  localparam logic [31:0] REG_RD_NR_HP     = 32'h0000_0200;
  localparam logic [31:0] REG_RD_HP        = 32'h0000_0300;
  localparam logic [31:0] REG_SET_THRESHOLD = 32'h0000_0300;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG_WR,
    ST_POLL_WAIT,
    ST_RD_NR,
    ST_RD_HP,
    ST_PUSH
  } drain_state_e;

  // Clamp the reported hot-page count to the per-poll burst limit.
  function automatic logic [31:0] cap_count(input logic [31:0] count, input logic [31:0] cap);
    return (count > cap) ? cap : count;
  endfunction

endpackage

// File: rtl/neoprof_hp_drain_master_if.sv
// Profiler-side AVMM master bus plus the hot-page stream toward the migration engine.
interface neoprof_hp_drain_master_if #(
  parameter int KEY_WIDTH = 32
) ();
  logic [31:0]          avm_address;
  logic                 avm_read;
  logic                 avm_write;
  logic [31:0]          avm_writedata;
  logic [3:0]           avm_byteenable;
  logic [31:0]          avm_readdata;
  logic                 avm_readdatavalid;
  logic                 avm_waitrequest;
  logic [KEY_WIDTH-1:0] hp_data_o;
  logic                 hp_valid_o;
  logic                 hp_ready_i;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest,
    output hp_data_o, hp_valid_o,
    input  hp_ready_i
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_readdata, avm_readdatavalid, avm_waitrequest,
    input  hp_data_o, hp_valid_o,
    output hp_ready_i
  );
endinterface

// File: rtl/neoprof_avmm_req.sv
// Single-outstanding AVMM request/response engine with a stall/response timeout.
// The timer restarts when a request is launched and again when a read is accepted,
// so waitrequest and readdatavalid each get a full TIMEOUT_CYCLES budget.
module neoprof_avmm_req #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  input  logic        avm_waitrequest,
  output logic        rsp_done,
  output logic [31:0] rsp_data,
  output logic        timeout
);

  localparam logic [31:0] TMR_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic        rd_pending;
  logic [31:0] tmr;
  logic        req_active;
  logic        accepted;
  logic        rd_capture;
  logic        waiting;

  // Decode acceptance, response capture and timeout from the current bus state.
  always_comb begin
    req_active = avm_read | avm_write;
    accepted   = req_active & ~avm_waitrequest;
    rd_capture = avm_readdatavalid & ((avm_read & ~avm_waitrequest) | rd_pending);
    rsp_done   = (avm_write & ~avm_waitrequest) | rd_capture;
    rsp_data   = avm_readdata;
    waiting    = (req_active & avm_waitrequest) | (rd_pending & ~avm_readdatavalid);
    timeout    = waiting & (tmr == TMR_LAST);
  end

  // Launch, hold, retire or abandon the single outstanding transaction.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      avm_address   <= '0;
      avm_writedata <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      rd_pending    <= 1'b0;
      tmr           <= '0;
    end else if (cmd_valid) begin
      avm_address   <= cmd_addr;
      avm_writedata <= cmd_wdata;
      avm_read      <= ~cmd_write;
      avm_write     <= cmd_write;
      rd_pending    <= 1'b0;
      tmr           <= '0;
    end else if (timeout) begin
      avm_read   <= 1'b0;
      avm_write  <= 1'b0;
      rd_pending <= 1'b0;
      tmr        <= '0;
    end else if (accepted) begin
      avm_read   <= 1'b0;
      avm_write  <= 1'b0;
      rd_pending <= avm_read & ~avm_readdatavalid;
      tmr        <= '0;
    end else if (rd_pending & avm_readdatavalid) begin
      rd_pending <= 1'b0;
    end else if (waiting) begin
      tmr <= tmr + 32'd1;
    end
  end

endmodule

// File: rtl/neoprof_hp_drain_master.sv
// Drains the NeoProf hot-page FIFO: optional threshold write, periodic count poll,
// one read per reported page, each page forwarded on a valid/ready stream.
module neoprof_hp_drain_master
  import neoprof_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int          POLL_INTERVAL  = 1024,
  parameter int          MAX_BURST      = 64,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter int          KEY_WIDTH      = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        thr_wr_en_i,
  input  logic [31:0] thr_i,
  neoprof_hp_drain_master_if.master bus,
  output logic        busy_o,
  output logic [31:0] drained_cnt_o,
  output logic        timeout_err_o
);

  localparam logic [31:0] POLL_LAST = 32'(POLL_INTERVAL - 1);
  localparam logic [31:0] BURST_CAP = 32'(MAX_BURST);
  localparam logic [31:0] ADDR_NR   = BASE_ADDR + REG_RD_NR_HP;
  localparam logic [31:0] ADDR_HP   = BASE_ADDR + REG_RD_HP;
  localparam logic [31:0] ADDR_THR  = BASE_ADDR + REG_SET_THRESHOLD;

  drain_state_e         state;
  drain_state_e         state_nxt;
  logic [31:0]          poll_cnt;
  logic [31:0]          remaining;
  logic                 stop_pend;
  logic                 hp_defer;
  logic [KEY_WIDTH-1:0] hp_data;
  logic                 hp_valid;
  logic                 push_hs;
  logic                 cmd_valid;
  logic                 cmd_write;
  logic [31:0]          cmd_addr;
  logic [31:0]          cmd_wdata;
  logic                 rsp_done;
  logic [31:0]          rsp_data;
  logic                 req_timeout;

  neoprof_avmm_req #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_req (
    .clk              (clk),
    .reset_n          (reset_n),
    .cmd_valid        (cmd_valid),
    .cmd_write        (cmd_write),
    .cmd_addr         (cmd_addr),
    .cmd_wdata        (cmd_wdata),
    .avm_address      (bus.avm_address),
    .avm_read         (bus.avm_read),
    .avm_write        (bus.avm_write),
    .avm_writedata    (bus.avm_writedata),
    .avm_readdata     (bus.avm_readdata),
    .avm_readdatavalid(bus.avm_readdatavalid),
    .avm_waitrequest  (bus.avm_waitrequest),
    .rsp_done         (rsp_done),
    .rsp_data         (rsp_data),
    .timeout          (req_timeout)
  );

  assign bus.avm_byteenable = 4'hF;
  assign bus.hp_data_o      = hp_data;
  assign bus.hp_valid_o     = hp_valid;
  assign busy_o             = (state != ST_IDLE);
  assign push_hs            = (state == ST_PUSH) & bus.hp_ready_i;

  // Next state and request launch; the RD_HP read following a count poll is
  // launched one cycle late so the bus always sees the previous request drop.
  always_comb begin
    state_nxt = state;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = ADDR_HP;
    cmd_wdata = 32'h0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          if (thr_wr_en_i) begin
            state_nxt = ST_CFG_WR;
            cmd_valid = 1'b1;
            cmd_write = 1'b1;
            cmd_addr  = ADDR_THR;
            cmd_wdata = thr_i;
          end else begin
            state_nxt = ST_POLL_WAIT;
          end
        end
      end
      ST_CFG_WR: begin
        if (req_timeout)   state_nxt = ST_IDLE;
        else if (rsp_done) state_nxt = ST_POLL_WAIT;
      end
      ST_POLL_WAIT: begin
        if (stop_pend) begin
          state_nxt = ST_IDLE;
        end else if (poll_cnt == POLL_LAST) begin
          state_nxt = ST_RD_NR;
          cmd_valid = 1'b1;
          cmd_addr  = ADDR_NR;
        end
      end
      ST_RD_NR: begin
        if (req_timeout) begin
          state_nxt = ST_IDLE;
        end else if (rsp_done) begin
          if (cap_count(rsp_data, BURST_CAP) == 32'h0) state_nxt = ST_POLL_WAIT;
          else                                         state_nxt = ST_RD_HP;
        end
      end
      ST_RD_HP: begin
        cmd_valid = hp_defer;
        if (req_timeout)   state_nxt = ST_IDLE;
        else if (rsp_done) state_nxt = ST_PUSH;
      end
      ST_PUSH: begin
        if (bus.hp_ready_i) begin
          if (stop_pend) begin
            state_nxt = ST_IDLE;
          end else if (remaining == 32'd1) begin
            state_nxt = ST_POLL_WAIT;
          end else begin
            state_nxt = ST_RD_HP;
            cmd_valid = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Poll timer, burst bookkeeping, stream register, stop latch and status flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      poll_cnt      <= '0;
      remaining     <= '0;
      stop_pend     <= 1'b0;
      hp_defer      <= 1'b0;
      hp_data       <= '0;
      hp_valid      <= 1'b0;
      drained_cnt_o <= '0;
      timeout_err_o <= 1'b0;
    end else begin
      poll_cnt <= ((state == ST_POLL_WAIT) && (state_nxt == ST_POLL_WAIT)) ? poll_cnt + 32'd1 : 32'd0;
      hp_defer <= (state == ST_RD_NR) && (state_nxt == ST_RD_HP);
      if (state == ST_IDLE) stop_pend <= 1'b0;
      else if (stop_i)      stop_pend <= 1'b1;
      if ((state == ST_RD_NR) && rsp_done) remaining <= cap_count(rsp_data, BURST_CAP);
      if ((state == ST_RD_HP) && rsp_done) begin
        hp_data  <= rsp_data[KEY_WIDTH-1:0];
        hp_valid <= 1'b1;
      end
      if (push_hs) begin
        hp_valid  <= 1'b0;
        remaining <= remaining - 32'd1;
        if (drained_cnt_o != 32'hFFFF_FFFF) drained_cnt_o <= drained_cnt_o + 32'd1;
      end
      if ((state == ST_IDLE) && start_i) timeout_err_o <= 1'b0;
      else if (req_timeout)              timeout_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_neoprof_hp_drain_master.sv
// Directed-plus-random bench for the hot-page drain master against a profiler slave model.
module tb_neoprof_hp_drain_master;

  localparam logic [31:0] BASE = 32'h0004_0000;
  localparam int          P    = 32;
  localparam int          MB   = 64;
  localparam int          TO   = 256;
  localparam int          KW   = 32;
  localparam logic [31:0] A_NR  = BASE + 32'h200;
  localparam logic [31:0] A_HP  = BASE + 32'h300;
  localparam logic [31:0] A_THR = BASE + 32'h300;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        thr_wr_en_i = 1'b0;
  logic [31:0] thr_i = 32'h0;
  logic        busy_o;
  logic [31:0] drained_cnt_o;
  logic        timeout_err_o;

  neoprof_hp_drain_master_if #(.KEY_WIDTH(KW)) bus ();

  neoprof_hp_drain_master #(
    .BASE_ADDR(BASE), .POLL_INTERVAL(P), .MAX_BURST(MB), .TIMEOUT_CYCLES(TO), .KEY_WIDTH(KW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .stop_i(stop_i),
    .thr_wr_en_i(thr_wr_en_i), .thr_i(thr_i), .bus(bus),
    .busy_o(busy_o), .drained_cnt_o(drained_cnt_o), .timeout_err_o(timeout_err_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } op_t;

  int          checks = 0;
  int          failures = 0;
  op_t         ops[$];
  logic [31:0] cnt_q[$];
  logic [31:0] page_q[$];
  logic [31:0] beats[$];
  logic [31:0] exp_beats[$];
  int unsigned rdnr_q[$];
  int unsigned last_hs_cyc = 0;
  int          stable_viol = 0;
  int          read_while_valid = 0;
  bit          stall_force = 0;
  bit          stall_hp = 0;
  int          ready_mode = 1;
  int          exp_drained = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit start, input bit stop, input bit thr_en, input logic [31:0] thr);
    @(negedge clk);
    start_i = start;
    stop_i = stop;
    thr_wr_en_i = thr_en;
    thr_i = thr;
    @(negedge clk);
    start_i = 0;
    stop_i = 0;
    thr_wr_en_i = 0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitBeats(input int target, input int budget, input string tag);
    int k = 0;
    while (beats.size() < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, beats.size(), target);
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int k = 0;
    while (busy_o && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, busy_o, 1'b0);
  endtask

  function automatic int countOps(input logic [31:0] addr, input bit wr);
    int n = 0;
    foreach (ops[i]) if (ops[i].addr == addr && ops[i].wr == wr) n++;
    return n;
  endfunction

  // Profiler slave model and stream sink: random stalls and read latency, FIFO pops on accepted reads.
  initial begin
    int          resp_cd;
    logic [31:0] resp_val;
    logic [31:0] val;
    bit          prev_read;
    bit          prev_valid;
    bit          prev_hs;
    logic [31:0] prev_data;
    int          lat;
    resp_cd = 0;
    resp_val = 0;
    prev_read = 0;
    prev_valid = 0;
    prev_hs = 0;
    prev_data = 0;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata = 32'h0;
    bus.hp_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        resp_cd = 0;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        bus.hp_ready_i = 1'b0;
        prev_valid = 0;
        prev_hs = 0;
        prev_read = 0;
        continue;
      end
      if (bus.hp_valid_o && prev_valid && !prev_hs && bus.hp_data_o !== prev_data) stable_viol++;
      if (bus.hp_valid_o && bus.avm_read) read_while_valid++;
      case (ready_mode)
        0:       bus.hp_ready_i = 1'b0;
        1:       bus.hp_ready_i = 1'b1;
        default: bus.hp_ready_i = 1'($urandom_range(0, 1));
      endcase
      if (bus.hp_valid_o && bus.hp_ready_i) begin
        beats.push_back(bus.hp_data_o);
        last_hs_cyc = cyc + 1;
      end
      prev_hs = bus.hp_valid_o && bus.hp_ready_i;
      prev_valid = bus.hp_valid_o;
      prev_data = bus.hp_data_o;
      bus.avm_readdatavalid = 1'b0;
      if (resp_cd > 0) begin
        resp_cd--;
        if (resp_cd == 0) begin
          bus.avm_readdatavalid = 1'b1;
          bus.avm_readdata = resp_val;
        end
      end
      if (bus.avm_read && !prev_read && bus.avm_address == A_NR) rdnr_q.push_back(cyc);
      prev_read = bus.avm_read;
      if (bus.avm_read || bus.avm_write) begin
        if (stall_force || (stall_hp && bus.avm_read && bus.avm_address == A_HP))
          bus.avm_waitrequest = 1'b1;
        else
          bus.avm_waitrequest = ($urandom_range(0, 3) == 0);
        if (!bus.avm_waitrequest) begin
          ops.push_back('{bus.avm_write, bus.avm_address, bus.avm_writedata, bus.avm_byteenable});
          if (bus.avm_read) begin
            if (bus.avm_address == A_NR)      val = (cnt_q.size() > 0) ? cnt_q.pop_front() : 32'h0;
            else if (bus.avm_address == A_HP) val = (page_q.size() > 0) ? page_q.pop_front() : 32'hBAD0_0000;
            else                              val = 32'hDEAD_BEEF;
            lat = $urandom_range(0, 2);
            if (lat == 0) begin
              bus.avm_readdatavalid = 1'b1;
              bus.avm_readdata = val;
            end else begin
              resp_cd = lat;
              resp_val = val;
            end
          end
        end
      end else begin
        bus.avm_waitrequest = 1'($urandom_range(0, 1));
        if (resp_cd == 0 && !bus.avm_readdatavalid && $urandom_range(0, 7) == 0) begin
          bus.avm_readdatavalid = 1'b1;
          bus.avm_readdata = $urandom;
        end
      end
    end
  end

  // Global time limit so the bench always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence of scenarios with randomized data and bus timing.
  initial begin
    int          k;
    int          base;
    int          hp_before;
    int          ops_before;
    logic [31:0] pg;

    waitCycles(3);
    checkOutput("rst_busy", busy_o, 1'b0);
    checkOutput("rst_read", bus.avm_read, 1'b0);
    checkOutput("rst_write", bus.avm_write, 1'b0);
    checkOutput("rst_addr", bus.avm_address, 32'h0);
    checkOutput("rst_wdata", bus.avm_writedata, 32'h0);
    checkOutput("rst_valid", bus.hp_valid_o, 1'b0);
    checkOutput("rst_drained", drained_cnt_o, 32'h0);
    checkOutput("rst_timeout", timeout_err_o, 1'b0);
    checkOutput("byteenable", bus.avm_byteenable, 4'hF);
    reset_n = 1'b1;
    waitCycles(2);

    $display("[TB] basic drain of three pages");
    ready_mode = 1;
    cnt_q.push_back(32'd3);
    page_q.push_back(32'h1000);
    page_q.push_back(32'h2000);
    page_q.push_back(32'h3000);
    exp_beats.push_back(32'h1000);
    exp_beats.push_back(32'h2000);
    exp_beats.push_back(32'h3000);
    exp_drained += 3;
    applyStimulus(1, 0, 0, 32'h0);
    waitBeats(3, 2000, "basic_beats");
    for (int i = 0; i < 3; i++) checkOutput("basic_order", beats[i], exp_beats[i]);
    k = 0;
    while ((rdnr_q.size() == 0 || rdnr_q[$] <= last_hs_cyc) && k < 4 * P) begin
      @(negedge clk);
      k++;
    end
    checkOutput("poll_gap", 64'(rdnr_q[$] - last_hs_cyc), 64'(P));
    checkOutput("basic_drained", drained_cnt_o, 32'(exp_drained));
    checkOutput("basic_hp_reads", countOps(A_HP, 0), 3);
    checkOutput("basic_no_write", countOps(A_THR, 1), 0);
    applyStimulus(0, 1, 0, 32'h0);
    waitIdle(2 * P, "basic_idle");

    $display("[TB] threshold write on start");
    ops.delete();
    applyStimulus(1, 0, 1, 32'h20);
    k = 0;
    while (ops.size() < 1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("thr_first_op_seen", ops.size() >= 1, 1'b1);
    checkOutput("thr_is_write", ops[0].wr, 1'b1);
    checkOutput("thr_addr", ops[0].addr, A_THR);
    checkOutput("thr_data", ops[0].data, 32'h20);
    checkOutput("thr_be", ops[0].be, 4'hF);
    applyStimulus(0, 1, 0, 32'h0);
    waitIdle(2 * P, "thr_idle");

    $display("[TB] count above burst cap with random pages and random ready");
    base = beats.size();
    hp_before = countOps(A_HP, 0);
    exp_beats.delete();
    cnt_q.push_back(32'd200);
    for (int i = 0; i < 200; i++) begin
      pg = $urandom;
      page_q.push_back(pg);
      if (i < MB) exp_beats.push_back(pg);
    end
    exp_drained += MB;
    ready_mode = 2;
    applyStimulus(1, 0, 0, 32'h0);
    waitBeats(base + MB, 8000, "burst_beats");
    waitCycles(3 * P);
    checkOutput("burst_no_extra", beats.size(), base + MB);
    for (int i = 0; i < MB; i++) checkOutput("burst_beat", beats[base + i], exp_beats[i]);
    checkOutput("burst_hp_reads", countOps(A_HP, 0) - hp_before, MB);
    checkOutput("burst_fifo_left", page_q.size(), 200 - MB);
    checkOutput("burst_drained", drained_cnt_o, 32'(exp_drained));
    checkOutput("burst_still_busy", busy_o, 1'b1);
    page_q.delete();
    ready_mode = 1;
    applyStimulus(0, 1, 0, 32'h0);
    waitIdle(4 * P, "burst_idle");

    $display("[TB] stream backpressure");
    base = beats.size();
    exp_beats.delete();
    cnt_q.push_back(32'd2);
    for (int i = 0; i < 2; i++) begin
      pg = $urandom;
      page_q.push_back(pg);
      exp_beats.push_back(pg);
    end
    exp_drained += 2;
    ready_mode = 0;
    applyStimulus(1, 0, 0, 32'h0);
    k = 0;
    while (!bus.hp_valid_o && k < 500) begin
      @(negedge clk);
      k++;
    end
    checkOutput("bp_valid_seen", bus.hp_valid_o, 1'b1);
    ops_before = ops.size();
    waitCycles(50);
    checkOutput("bp_valid_held", bus.hp_valid_o, 1'b1);
    checkOutput("bp_data_held", bus.hp_data_o, exp_beats[0]);
    checkOutput("bp_no_beat", beats.size(), base);
    checkOutput("bp_no_bus_op", ops.size(), ops_before);
    ready_mode = 1;
    waitBeats(base + 2, 500, "bp_beats");
    waitCycles(2 * P);
    checkOutput("bp_consumed_once", beats.size(), base + 2);
    checkOutput("bp_beat0", beats[base], exp_beats[0]);
    checkOutput("bp_beat1", beats[base + 1], exp_beats[1]);
    checkOutput("bp_drained", drained_cnt_o, 32'(exp_drained));
    applyStimulus(0, 1, 0, 32'h0);
    waitIdle(4 * P, "bp_idle");

    $display("[TB] waitrequest timeout");
    stall_force = 1;
    applyStimulus(1, 0, 0, 32'h0);
    k = 0;
    while (!bus.avm_read && k < 4 * P) begin
      @(negedge clk);
      k++;
    end
    checkOutput("to_read_seen", bus.avm_read, 1'b1);
    waitCycles(TO - 1);
    checkOutput("to_err_before", timeout_err_o, 1'b0);
    checkOutput("to_read_before", bus.avm_read, 1'b1);
    waitCycles(1);
    checkOutput("to_err", timeout_err_o, 1'b1);
    checkOutput("to_read_dropped", bus.avm_read, 1'b0);
    checkOutput("to_busy", busy_o, 1'b0);
    waitCycles(300 - TO);
    stall_force = 0;
    checkOutput("to_err_sticky", timeout_err_o, 1'b1);
    applyStimulus(1, 0, 0, 32'h0);
    checkOutput("to_err_cleared", timeout_err_o, 1'b0);
    applyStimulus(0, 1, 0, 32'h0);
    waitIdle(4 * P, "to_idle");

    $display("[TB] stop during stalled hot-page read");
    base = beats.size();
    exp_beats.delete();
    cnt_q.push_back(32'd3);
    for (int i = 0; i < 3; i++) begin
      pg = $urandom;
      page_q.push_back(pg);
      exp_beats.push_back(pg);
    end
    exp_drained += 1;
    stall_hp = 1;
    ready_mode = 1;
    hp_before = countOps(A_HP, 0);
    applyStimulus(1, 0, 0, 32'h0);
    k = 0;
    while (!(bus.avm_read && bus.avm_address == A_HP) && k < 8 * P) begin
      @(negedge clk);
      k++;
    end
    checkOutput("stop_hp_seen", bus.avm_read, 1'b1);
    applyStimulus(0, 1, 0, 32'h0);
    waitCycles(20);
    stall_hp = 0;
    waitIdle(200, "stop_idle");
    ops_before = ops.size();
    waitCycles(3 * P);
    checkOutput("stop_beats", beats.size(), base + 1);
    checkOutput("stop_page", beats[base], exp_beats[0]);
    checkOutput("stop_hp_reads", countOps(A_HP, 0) - hp_before, 1);
    checkOutput("stop_fifo_left", page_q.size(), 2);
    checkOutput("stop_no_more_ops", ops.size(), ops_before);
    checkOutput("stop_drained", drained_cnt_o, 32'(exp_drained));
    page_q.delete();

    $display("[TB] start with stop in idle, start while busy");
    ops.delete();
    applyStimulus(1, 1, 0, 32'h0);
    checkOutput("startstop_busy", busy_o, 1'b1);
    waitCycles(P / 2);
    applyStimulus(1, 0, 1, 32'h77);
    waitCycles(2 * P);
    checkOutput("startstop_still_busy", busy_o, 1'b1);
    checkOutput("busy_start_ignored", countOps(A_THR, 1), 0);
    applyStimulus(0, 1, 0, 32'h0);
    waitIdle(4 * P, "final_idle");

    checkOutput("stream_stable", stable_viol, 0);
    checkOutput("no_read_while_valid", read_while_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neoprof_hp_drain_master.md
Name: neoprof_hp_drain_master

Overview:
- AVMM master that drains the NeoProf profiler's hot-page FIFO over the profiler's AVMM register interface.
- Optionally programs the hotness threshold on start, then polls the hot-page count periodically.
- Issues one hot-page read per reported entry and forwards each page address on a valid/ready stream toward the migration engine.
- Sits on the slow profiler clock, beside the profiler slave; one outstanding transaction at a time.

Parameters:
- BASE_ADDR, 32'h0, profiler register window base; added to every register offset.
- POLL_INTERVAL, 1024, idle cycles between count polls.
- MAX_BURST, 64, max hot-page reads per poll (count is capped to this).
- TIMEOUT_CYCLES, 256, max cycles waiting on waitrequest or readdatavalid.
- KEY_WIDTH, 32, hot-page address width (<=32).

Ports:
- clk  in  1  profiler clock
- reset_n  in  1  synchronous active-low reset
- start_i  in  1  pulse: begin draining
- stop_i  in  1  pulse: finish current transaction, then return to IDLE
- thr_wr_en_i  in  1  on start, write thr_i to SET_THRESHOLD first
- thr_i  in  32  threshold value
- avm_address  out  32  AVMM address
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_writedata  out  32  write data
- avm_byteenable  out  4  always 4'hF
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data valid
- avm_waitrequest  in  1  slave stall
- hp_data_o  out  KEY_WIDTH  hot-page address
- hp_valid_o  out  1  stream valid
- hp_ready_i  in  1  stream ready
- busy_o  out  1  state != IDLE
- drained_cnt_o  out  32  saturating count of pages forwarded
- timeout_err_o  out  1  sticky; cleared by start_i

Behaviour:
- Offsets: SET_THRESHOLD write 0x300; RD_NR_HP read 0x200; RD_HP read 0x300.
- Reset (reset_n=0 at clk edge): state IDLE; avm_read/avm_write 0; avm_address/avm_writedata 0; hp_valid_o 0; drained_cnt_o 0; timeout_err_o 0; internal counters 0. Reset mid-transaction aborts it without completing the handshake.
- AVMM request: address/data/read/write driven from registers and held stable while avm_waitrequest=1.
  - Transaction accepted on the first edge with the request high and waitrequest=0.
  - Request dropped on the next cycle.
- Read response: captured on the first edge with readdatavalid=1, at or after acceptance. readdatavalid is ignored when no read is outstanding.
- States:
  - IDLE: start_i -> CFG_WR if thr_wr_en_i, else POLL_WAIT. start_i clears timeout_err_o.
  - CFG_WR: write thr_i to BASE_ADDR+0x300 -> on accept, POLL_WAIT.
  - POLL_WAIT: count to POLL_INTERVAL-1 -> RD_NR.
  - RD_NR: read BASE_ADDR+0x200 -> response: remaining = min(readdata, MAX_BURST). remaining==0 -> POLL_WAIT; else RD_HP.
  - RD_HP: read BASE_ADDR+0x300 -> response: latch readdata[KEY_WIDTH-1:0] into hp_data_o, assert hp_valid_o -> PUSH.
  - PUSH: hold hp_data_o/hp_valid_o until hp_ready_i; on handshake decrement remaining and saturating-increment drained_cnt_o. remaining==0 -> POLL_WAIT; else RD_HP. No new read is issued while hp_valid_o=1 (backpressure stalls the bus).
- stop_i: latched; honoured only in POLL_WAIT or after a completed PUSH handshake -> IDLE. Never abandons an accepted read, because hot-page reads pop the profiler FIFO.
- Timeout: counter resets on each new request. If waitrequest stays high, or readdatavalid does not arrive, for TIMEOUT_CYCLES cycles -> drop request, set timeout_err_o, go to IDLE.
- start_i while busy: ignored.
- Simultaneous start_i and stop_i in IDLE: start wins, stop is discarded.

Decomposition:
- Shared package neoprof_pkg: register offset localparams shared with the profiler slave (RD_NR_HP, RD_HP, SET_THRESHOLD, RESET, ...) and the state enum.
- Natural sub-module: neoprof_avmm_req, a single-outstanding AVMM request/response engine with timeout, reused by future host-side masters.

Test Plan:
- Slave model reports count=3 then pages 0x1000/0x2000/0x3000, hp_ready_i=1 -> three stream beats in that order; drained_cnt_o=3; next RD_NR issued POLL_INTERVAL cycles after the last handshake.
- thr_wr_en_i=1, thr_i=0x20 -> first bus op is a write of 0x20 to BASE_ADDR+0x300 with byteenable 4'hF, before any read.
- Count=200, MAX_BURST=64 -> exactly 64 RD_HP reads, then return to POLL_WAIT.
- hp_ready_i low for 50 cycles after the first beat -> hp_data_o stable throughout, no avm_read asserted, beat consumed once.
- waitrequest held high 300 cycles with TIMEOUT_CYCLES=256 -> timeout_err_o=1 at cycle 256, avm_read=0, busy_o=0; a later start_i clears the flag.
- stop_i asserted while RD_HP is stalled by waitrequest -> read completes, page is forwarded, then IDLE with no further reads.
